detect_faces_mul_pipe: RTL
==========================

# detect_faces_mul_pipe

Parametrised, pipelined successor to the face-detector's combinational fixed-width multipliers. It accepts operand pairs over a valid/ready stream and applies per-operand signedness. A configurable number of register stages give timing closure on the scaling and window-normalisation datapaths. An optional accumulate mode folds a burst of products into one result for integral-image and classifier-weight sums.

## Interface
- `din0_WIDTH`, 16: operand 0 width.
- `din1_WIDTH`, 10: operand 1 width.
- `dout_WIDTH`, 25: result width.
- `NUM_STAGE`, 3: pipeline depth in cycles. Legal range is 0..8.
- `DIN0_SIGNED`, 0: 1 means din0 is two's complement.
- `DIN1_SIGNED`, 0: 1 means din1 is two's complement.
- `ap_clk`, in, 1: the only clock. All logic samples on its rising edge.
- `ap_rst`, in, 1: reset, synchronous and active-high.
- `in_valid`, in, 1: operand beat present.
- `in_ready`, out, 1: block accepts the beat this cycle.
- `din0`, in, din0_WIDTH: operand 0.
- `din1`, in, din1_WIDTH: operand 1.
- `in_last`, in, 1: final beat of an accumulate burst.
- `out_valid`, out, 1: result present.
- `out_ready`, in, 1: downstream accepts the result.
- `dout`, out, dout_WIDTH: result.
- `out_last`, out, 1: marks the final result of a burst.

## Operation
- **Operand extension:** each operand is extended by 1 bit. A signed operand is sign-extended; an unsigned operand is zero-extended.
- **Product:** the full signed product of the extended operands, width din0_WIDTH+din1_WIDTH+2.
- **Result width:**
  - The product is truncated to the low dout_WIDTH bits (modulo wrap, no saturation).
  - If dout_WIDTH exceeds the product width, the product is sign-extended.
- **Transfer rule:** a beat transfers when valid and ready are both high in the same cycle. This applies on both the input and output sides.
- **Pipeline structure:**
  - The pipeline is a chain of NUM_STAGE slices. Each slice holds a valid bit, data and last.
  - Stage 1 registers the extended operands.
  - The multiply is placed after stage 1. All later stages register the product.
- **Stall:** advance = !out_valid || out_ready. When advance is low, every slice holds its contents. Bubbles are not squeezed.
- **Input ready:** in_ready = advance. It is combinational from out_ready and the final valid bit.
- **NUM_STAGE = 0:** the block is purely combinational. in_ready = out_ready, out_valid = in_valid, out_last = in_last.
- **in_last:** travels with its beat unchanged.

## Timing
- **Latency:** NUM_STAGE cycles from input transfer to out_valid, when there is no stall.
- **Throughput:** 1 beat per cycle.
- **Reset:** while ap_rst is high, all valid bits and the accumulator clear. On the cycle after reset:
  - out_valid = 0, out_last = 0, dout = 0.
  - in_ready = 1.
- **Reset mid-operation:** all in-flight beats and any partial accumulation are discarded. There is no output for them.
- **Backpressure:** while out_valid && !out_ready, dout and out_last must stay stable. No beat may be lost or duplicated.
- **Simultaneous input and output transfer:** the pipeline shifts by one.
- **Reset dominance:** if in_valid and ap_rst are high in the same cycle, reset wins and the beat is dropped.

## Configuration
- **Macro:** `DETECT_FACES_MUL_ACC_EN`.
- **When defined:**
  - An accumulator register of dout_WIDTH bits follows the last stage.
  - Each product is added to the accumulator, with modulo-dout_WIDTH wrap.
  - out_valid is raised only for beats carrying last. On those beats, dout = accumulator + product.
  - The accumulator clears when that result transfers.
  - Non-last beats produce no output and are consumed without stalling.
  - Latency becomes NUM_STAGE+1.
  - A burst of length 1 (in_last on the first beat) returns the bare product.
- **When absent:** every product is emitted, in_last is forwarded to out_last, and no accumulator exists.

## Structure
- **Package `detect_faces_mul_pkg`:**
  - Function `prod_width(w0,w1)`, returning w0+w1+2.
  - Constant `MAX_STAGE = 8`.
  - Function `ext_operand(value, width, signed_flag)`.
- **Sub-module `detect_faces_mul_slice`:** one stall-able register slice (valid, data, last, with an enable input). It is instantiated in a generate loop NUM_STAGE times. Stage 1 uses a data width equal to the extended operand pair; later stages use the product width.
- **Top level:** holds the multiply, the truncation, the handshake logic and the optional accumulator.

## Test plan
- **Max unsigned operands, defaults:** din0=16'hFFFF, din1=10'h3FF. Expect dout=25'h1FEFC01 (wrapped from 0x3FEFC01), exactly 3 cycles after acceptance.
- **Signed operand:** DIN0_SIGNED=1, din0=16'hFFFF (−1), din1=3. Expect dout=25'h1FFFFFD (−3).
- **Backpressure:** stream 10 beats din0=i, din1=i+1 with out_ready low on cycles 4–8. Expect in_ready low during the stall, dout held stable, and all 10 products i·(i+1) delivered in order exactly once.
- **Reset mid-stream:** assert ap_rst for 1 cycle while 3 beats are in flight. Expect out_valid=0 the next cycle, none of the 3 results appear, and the next accepted beat returns its correct product after 3 cycles.
- **Accumulate mode (ACC_EN):** send beats (2,3), (4,5), (6,7,last). Expect a single result dout=68 with out_last=1. A following single beat (9,9,last) gives 81, proving the accumulator cleared.
- **NUM_STAGE=0:** din0=100, din1=5. Expect dout=500 in the same cycle, with in_ready tracking out_ready combinationally.

Source files
------------

// File: rtl/detect_faces_mul_pkg.sv
// Shared width helpers and operand extension for the detect_faces_mul_pipe multiplier.
package detect_faces_mul_pkg;

   localparam int MAX_STAGE = 8;

   function automatic int prod_width(input int w0, input int w1);
      return w0 + w1 + 2;
   endfunction

   // Keeps the low `width` bits of value and fills everything above with the
   // operand's sign (signed) or zero (unsigned); callers slice width+1 bits.
   function automatic logic [63:0] ext_operand(input logic [63:0] value,
                                               input int          width,
                                               input logic        signed_flag);
      logic [63:0] mask;
      logic        sign;
      mask = (width >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << width) - 64'd1);
      sign = signed_flag & (|(value & (64'd1 << (width - 1))));
      return (value & mask) | ({64{sign}} & ~mask);
   endfunction

endpackage

// File: rtl/detect_faces_mul_slice.sv
// One stall-able register slice: valid, data and last move together when en is high.
module detect_faces_mul_slice
   import detect_faces_mul_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   input  logic         in_last,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic         out_last
);

   // Slice register; holds everything while en is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (en) begin
         out_valid <= in_valid;
         out_data  <= in_data;
         out_last  <= in_last;
      end
   end

endmodule

// File: rtl/detect_faces_mul_pipe.sv
// Pipelined operand-pair multiplier with valid/ready handshake on both sides.
// Defining DETECT_FACES_MUL_ACC_EN adds a burst accumulator after the last stage.
module detect_faces_mul_pipe
   import detect_faces_mul_pkg::*;
#(
   parameter int din0_WIDTH  = 16,
   parameter int din1_WIDTH  = 10,
   parameter int dout_WIDTH  = 25,
   parameter int NUM_STAGE   = 3,
   parameter int DIN0_SIGNED = 0,
   parameter int DIN1_SIGNED = 0
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [dout_WIDTH-1:0] dout,
   output logic                  out_last
);

   localparam int E0 = din0_WIDTH + 1;
   localparam int E1 = din1_WIDTH + 1;
   localparam int PW = prod_width(din0_WIDTH, din1_WIDTH);
   localparam int NS = (NUM_STAGE > MAX_STAGE) ? MAX_STAGE : NUM_STAGE;

   // Product of the two extended operands packed as {ext0, ext1}; both are
   // sign-extended to PW so the low PW bits of the product are exact.
   function automatic logic [PW-1:0] mul_pair(input logic [PW-1:0] pair);
      logic [PW-1:0] a;
      logic [PW-1:0] b;
      a = {{(PW-E0){pair[PW-1]}}, pair[PW-1 -: E0]};
      b = {{(PW-E1){pair[E1-1]}}, pair[E1-1:0]};
      return a * b;
   endfunction

   logic [E0-1:0] ext0;
   logic [E1-1:0] ext1;
   logic          advance;

   assign ext0 = E0'(ext_operand(64'(din0), din0_WIDTH, DIN0_SIGNED != 0));
   assign ext1 = E1'(ext_operand(64'(din1), din1_WIDTH, DIN1_SIGNED != 0));

   logic [PW-1:0] stg_data  [0:NS];
   logic          stg_valid [0:NS];
   logic          stg_last  [0:NS];

   assign stg_data[0]  = {ext0, ext1};
   assign stg_valid[0] = in_valid;
   assign stg_last[0]  = in_last;

   genvar k;
   generate
      for (k = 1; k <= NS; k++) begin : g_stage
         logic [PW-1:0] slice_in;
         if (k == 2) begin : g_mul
            assign slice_in = mul_pair(stg_data[1]);
         end else begin : g_pass
            assign slice_in = stg_data[k-1];
         end
         detect_faces_mul_slice #(.W(PW)) u_slice (
            .clk       (ap_clk),
            .rst       (ap_rst),
            .en        (advance),
            .in_valid  (stg_valid[k-1]),
            .in_data   (slice_in),
            .in_last   (stg_last[k-1]),
            .out_valid (stg_valid[k]),
            .out_data  (stg_data[k]),
            .out_last  (stg_last[k])
         );
      end
   endgenerate

   // With fewer than two stages the multiply sits after the last register.
   logic [PW-1:0]         prod;
   logic [dout_WIDTH-1:0] res;
   logic                  fin_valid;
   logic                  fin_last;

   generate
      if (NS < 2) begin : g_prod_comb
         assign prod = mul_pair(stg_data[NS]);
      end else begin : g_prod_reg
         assign prod = stg_data[NS];
      end
      if (dout_WIDTH < PW) begin : g_trunc
         logic prod_unused;
         assign prod_unused = ^prod[PW-1:dout_WIDTH];
         assign res = prod[dout_WIDTH-1:0];
      end else if (dout_WIDTH == PW) begin : g_exact
         assign res = prod;
      end else begin : g_sext
         assign res = {{(dout_WIDTH-PW){prod[PW-1]}}, prod};
      end
   endgenerate

   assign fin_valid = stg_valid[NS];
   assign fin_last  = stg_last[NS];

`ifdef DETECT_FACES_MUL_ACC_EN
   logic [dout_WIDTH-1:0] acc;
   logic [dout_WIDTH-1:0] acc_dout;
   logic                  acc_valid;
   logic                  acc_last;

   assign advance   = !acc_valid || out_ready;
   assign in_ready  = advance;
   assign out_valid = acc_valid;
   assign out_last  = acc_last;
   assign dout      = acc_dout;

   // Output/accumulator stage: only last beats raise out_valid; the running
   // sum restarts once the burst total has been captured for output.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         acc       <= '0;
         acc_dout  <= '0;
         acc_valid <= 1'b0;
         acc_last  <= 1'b0;
      end else if (advance) begin
         acc_valid <= fin_valid & fin_last;
         acc_last  <= fin_valid & fin_last;
         if (fin_valid) begin
            if (fin_last) begin
               acc_dout <= acc + res;
               acc      <= '0;
            end else begin
               acc      <= acc + res;
            end
         end
      end
   end
`else
   generate
      if (NS == 0) begin : g_adv_comb
         assign advance = out_ready;
      end else begin : g_adv_reg
         assign advance = !fin_valid || out_ready;
      end
   endgenerate

   assign in_ready  = advance;
   assign out_valid = fin_valid;
   assign out_last  = fin_last;
   assign dout      = res;
`endif

endmodule
